// File: rtl/la_capture.sv
// Logic-analyser capture: waits for a masked trigger on the registered probe, records
// DEPTH consecutive samples, then streams them out over a valid/ready port.
module la_capture #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] probe,
   input  logic             arm,
   input  logic             abort,
   input  logic [WIDTH-1:0] trig_mask,
   input  logic [WIDTH-1:0] trig_value,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       state,
   output logic             done
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DUMP    = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sample_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_valid_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             trig_hit_s;
   logic             accept_s;
   logic             mem_we_s;
   logic [AW-1:0]    mem_waddr_s;
   logic [AW-1:0]    rd_next_s;

   // Trigger compare, handshake decode and capture-memory write control.
   always_comb begin
      trig_hit_s  = ((sample_q ^ trig_value) & trig_mask) == {WIDTH{1'b0}};
      accept_s    = out_valid_q & out_ready;
      rd_next_s   = rd_ptr_q + AW'(1);
      mem_we_s    = 1'b0;
      mem_waddr_s = {AW{1'b0}};
      if (abort) begin
         mem_we_s = 1'b0;
      end else if ((state_q == ST_ARMED) && trig_hit_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = {AW{1'b0}};
      end else if (state_q == ST_CAPTURE) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = wr_ptr_q;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Capture memory; deliberately not reset, its contents only matter after a full capture.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= sample_q;
      end
   end

   // Probe register, control FSM, pointers and registered readout port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sample_q    <= {WIDTH{1'b0}};
         out_data_q  <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
      end else begin
         sample_q <= probe;
         if (abort) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (arm) begin
                     state_q <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  if (trig_hit_s) begin
                     state_q  <= ST_CAPTURE;
                     wr_ptr_q <= AW'(1);
                  end
               end
               ST_CAPTURE: begin
                  // The final write lands this edge, so mem[0] is long settled for the first read.
                  if (wr_ptr_q == LAST_PTR) begin
                     state_q     <= ST_DUMP;
                     wr_ptr_q    <= {AW{1'b0}};
                     rd_ptr_q    <= {AW{1'b0}};
                     out_valid_q <= 1'b1;
                     out_data_q  <= mem_q[{AW{1'b0}}];
                  end else begin
                     wr_ptr_q <= wr_ptr_q + AW'(1);
                  end
               end
               ST_DUMP: begin
                  if (accept_s) begin
                     if (rd_ptr_q == LAST_PTR) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        rd_ptr_q    <= {AW{1'b0}};
                     end else begin
                        rd_ptr_q   <= rd_next_s;
                        out_data_q <= mem_q[rd_next_s];
                     end
                  end
               end
               default: begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  wr_ptr_q    <= {AW{1'b0}};
                  rd_ptr_q    <= {AW{1'b0}};
               end
            endcase
         end
      end
   end

   // done marks the accepting cycle itself, so it is decoded from the live handshake.
   always_comb begin
      done = (state_q == ST_DUMP) && accept_s && (rd_ptr_q == LAST_PTR) && !abort;
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign state     = state_q;

endmodule

// File: tb/tb_la_capture.sv
// Scoreboard bench for la_capture: a transaction-level model predicts each capture from the
// probe values driven after arm; a monitor checks every dumped sample, stall and done pulse.
`timescale 1ns/1ps
module tb_la_capture;

   localparam int DEPTH   = 256;
   localparam int WIDTH   = 8;
   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_CAPT  = 2;
   localparam int M_DUMP  = 3;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] probe;
   logic             arm;
   logic             abort;
   logic [WIDTH-1:0] trig_mask;
   logic [WIDTH-1:0] trig_value;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       state;
   logic             done;

   int               n_cmp   = 0;
   int               n_bad   = 0;
   int               mode    = M_IDLE;
   int               cap_cnt = 0;
   logic [7:0]       exp_q[$];
   bit               cnt_mode = 1'b0;
   logic [7:0]       ctr      = 8'h00;
   logic [7:0]       popped;

   la_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .probe      (probe),
      .arm        (arm),
      .abort      (abort),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .state      (state),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run still going at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic bound_expired(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: cycle budget expired, got no progress, expected completion at %0t", name, $time);
   endtask

   // One clock of stimulus; the model sees exactly the probe value the DUT will register.
   task automatic cycle(input bit a, input bit ab, input bit rdy);
      logic [7:0] p;
      @(negedge clk);
      if (cnt_mode) begin
         p   = ctr;
         ctr = ctr + 8'd1;
      end else begin
         p = 8'($urandom);
      end
      probe     = p;
      arm       = a;
      abort     = ab;
      out_ready = rdy;
      if (ab) begin
         exp_q.delete();
         mode    = M_IDLE;
         cap_cnt = 0;
      end else begin
         if (mode == M_IDLE && a) mode = M_ARMED;
         if (mode == M_ARMED) begin
            if (((p ^ trig_value) & trig_mask) == 8'h00) begin
               exp_q.push_back(p);
               cap_cnt = 1;
               mode    = M_CAPT;
            end
         end else if (mode == M_CAPT) begin
            exp_q.push_back(p);
            cap_cnt++;
            if (cap_cnt == DEPTH) mode = M_DUMP;
         end
      end
   endtask

   task automatic run_until_idle(input int budget, input int rdy_pct, input bit arm_noise);
      for (int i = 0; i < budget; i++) begin
         cycle(arm_noise && ($urandom_range(0, 9) == 0), 1'b0, $urandom_range(0, 99) < rdy_pct);
         #2;
         if (mode == M_IDLE) return;
      end
      bound_expired("capture_complete");
      cycle(1'b0, 1'b1, 1'b1);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         #1;
         chk("idle_state", 32'(state), 32'd0);
         chk("idle_valid", 32'(out_valid), 32'd0);
      end
   endtask

   task automatic post_abort_check(input string name);
      cycle(1'b0, 1'b0, 1'b1);
      #1;
      chk({name, "_state"}, 32'(state), 32'd0);
      chk({name, "_valid"}, 32'(out_valid), 32'd0);
   endtask

   // Monitor: pops the scoreboard on every accepted sample and polices stalls and done.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (abort) begin
               chk("done_on_abort", 32'(done), 32'd0);
            end else if (out_valid) begin
               if (mode != M_DUMP || exp_q.size() == 0) begin
                  chk("spurious_valid", 32'(out_valid), 32'd0);
               end else if (out_ready) begin
                  chk("dump_data", 32'(out_data), 32'(exp_q[0]));
                  popped = exp_q.pop_front();
                  chk("done_pulse", 32'(done), (exp_q.size() == 0) ? 32'd1 : 32'd0);
                  if (exp_q.size() == 0) mode = M_IDLE;
               end else begin
                  chk("stall_data", 32'(out_data), 32'(exp_q[0]));
                  chk("done_stall", 32'(done), 32'd0);
               end
            end else begin
               chk("done_idle", 32'(done), 32'd0);
            end
         end
      end
   end

   initial begin
      bit reached;
      rst        = 1'b1;
      arm        = 1'b0;
      abort      = 1'b0;
      out_ready  = 1'b0;
      probe      = 8'h00;
      trig_mask  = 8'hFF;
      trig_value = 8'h10;
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_check(3);

      // Counter probe, exact-match trigger on 0x10.
      cnt_mode = 1'b1; ctr = 8'h00; trig_mask = 8'hFF; trig_value = 8'h10;
      cycle(1'b1, 1'b0, 1'b1);
      run_until_idle(1500, 100, 1'b0);
      idle_check(2);

      // Empty mask: trigger on the first ARMED cycle.
      cnt_mode = 1'b0; trig_mask = 8'h00;
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      #1 chk("mask0_armed", 32'(state), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);
      #1 chk("mask0_capture", 32'(state), 32'd2);
      run_until_idle(1500, 100, 1'b0);
      idle_check(2);

      // Random probe, ~30% backpressure, stray arm pulses during capture and dump.
      for (int k = 0; k < 3; k++) begin
         trig_mask  = 8'h03 << $urandom_range(0, 6);
         trig_value = 8'($urandom);
         cycle(1'b1, 1'b0, 1'b1);
         run_until_idle(3000, 70, 1'b1);
         idle_check(4);
      end

      // Abort while ARMED (trigger value far ahead of the counter).
      cnt_mode = 1'b1; ctr = 8'h20; trig_mask = 8'hFF; trig_value = 8'h10;
      cycle(1'b1, 1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, 1'b1);
      #1 chk("armed_state", 32'(state), 32'd1);
      cycle(1'b1, 1'b1, 1'b1);
      post_abort_check("abort_armed");

      // Abort beats a simultaneous arm in IDLE.
      cycle(1'b1, 1'b1, 1'b1);
      post_abort_check("abort_vs_arm");

      // Abort mid-CAPTURE around wr_ptr=100.
      cnt_mode = 1'b0; trig_mask = 8'h00;
      cycle(1'b1, 1'b0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 400 && !reached; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         reached = (mode == M_CAPT) && (cap_cnt >= 101);
      end
      if (!reached) bound_expired("reach_wr100");
      cycle(1'b0, 1'b1, 1'b1);
      post_abort_check("abort_capture");
      idle_check(2);

      // Abort in DUMP at rd_ptr=5 together with a handshake.
      cycle(1'b1, 1'b0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 1500 && !reached; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         #2;
         reached = (mode == M_DUMP) && (exp_q.size() == DEPTH - 5);
      end
      if (!reached) bound_expired("reach_rd5");
      cycle(1'b0, 1'b1, 1'b1);
      post_abort_check("abort_dump");
      idle_check(2);

      // Abort on the final handshake: no done pulse.
      cycle(1'b1, 1'b0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 2500 && !reached; i++) begin
         cycle(1'b0, 1'b0, $urandom_range(0, 1) == 1);
         #2;
         reached = (mode == M_DUMP) && (exp_q.size() == 1);
      end
      if (!reached) bound_expired("reach_last");
      cycle(1'b0, 1'b1, 1'b1);
      post_abort_check("abort_last");
      idle_check(2);

      // Asynchronous reset pulse between edges mid-CAPTURE, then a fresh capture.
      cycle(1'b1, 1'b0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 400 && !reached; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         reached = (mode == M_CAPT) && (cap_cnt >= 60);
      end
      if (!reached) bound_expired("reach_wr60");
      #3 rst = 1'b1;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      mode    = M_IDLE;
      cap_cnt = 0;
      idle_check(3);
      cnt_mode = 1'b1; trig_mask = 8'hFF; trig_value = 8'($urandom);
      cycle(1'b1, 1'b0, 1'b1);
      run_until_idle(1500, 70, 1'b1);
      idle_check(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
